// File: rtl/clkdiv_cfg_ctrl_pkg.sv
// Shared types and constants for the odd_div reconfiguration sequencer.
// Provides the sequencer state encoding and the default divide-value width.
package clkdiv_ctrl_pkg;

  localparam int CLKDIV_W   = 8;
  localparam int CLKDIV_MIN = 2;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_WAIT_LOW,
    ST_GATE,
    ST_RESET,
    ST_RELEASE
  } clkdiv_state_e;

endpackage

// File: rtl/clkdiv_cfg_ctrl_if.sv
// Request/status bus between the clock-configuration registers (master)
// and the reconfiguration sequencer (slave).
interface clkdiv_cfg_ctrl_if
  import clkdiv_ctrl_pkg::*;
#(
  parameter int DIV_W = CLKDIV_W
);

  logic             req_valid;
  logic [DIV_W-1:0] req_div;
  logic             req_ready;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req_valid,
    output req_div,
    input  req_ready,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_div,
    output req_ready,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/clkdiv_cfg_ctrl_edge_det.sv
// Edge/level detector for the divided clock as seen on the system clock.
// Pairs the live sample with the previous registered sample so the
// sequencer can act on the edge where the sample is taken.
module clkdiv_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic i_sample,
  output logic o_low2,
  output logic o_rise
);

  logic r_prev;

  // Hold the previous edge's sample; start high so no false rise after reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_sample;
    end
  end

  assign o_low2 = ~i_sample & ~r_prev;
  assign o_rise = i_sample & ~r_prev;

endmodule

// File: rtl/clkdiv_cfg_ctrl.sv
// Glitch-free reconfiguration sequencer for the odd_div clock divider.
// Waits for the divided clock to be low, gates it, holds the divider in
// reset while the divide value changes, then re-enables the gate on the
// first new rising edge.
// Optional feature macro: CLKDIV_CFG_CTRL_TIMEOUT_EN adds a timeout on the
// WAIT_LOW and RELEASE states.
module clkdiv_cfg_ctrl
  import clkdiv_ctrl_pkg::*;
#(
  parameter int DIV_W     = CLKDIV_W,
  parameter int DIV_MIN   = CLKDIV_MIN,
  parameter int DIV_RESET = 4,
  parameter int GATE_CYC  = 1,
  parameter int RST_CYC   = 2,
  parameter int TMO_CYC   = 512
) (
  input  logic                clk,
  input  logic                resetn,
  clkdiv_cfg_ctrl_if.slave    bus,
  input  logic                clkout_in,
  output logic [DIV_W-1:0]    div_val,
  output logic                div_resetn,
  output logic                gate_en
);

  // Counter sized to cover the timeout span; also times GATE and RESET
  localparam int CNT_W = $clog2(TMO_CYC + 1);

  clkdiv_state_e    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_pend;
  logic [DIV_W-1:0] r_div_val;
  logic             r_div_resetn;
  logic             r_gate_en;
  logic             r_req_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_low2;
  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_wl_tmo;
  logic             w_rel_tmo;

  clkdiv_edge_det u_edge_det (
    .clk      (clk),
    .resetn   (resetn),
    .i_sample (clkout_in),
    .o_low2   (w_low2),
    .o_rise   (w_rise)
  );

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

`ifdef CLKDIV_CFG_CTRL_TIMEOUT_EN
  assign w_wl_tmo  = (r_state == ST_WAIT_LOW) && (r_cnt == CNT_W'(TMO_CYC - 1));
  assign w_rel_tmo = (r_state == ST_RELEASE)  && (r_cnt == CNT_W'(TMO_CYC - 1));
`else
  assign w_wl_tmo  = 1'b0;
  assign w_rel_tmo = 1'b0;
`endif

  // Sequencer: state, cycle counter and every registered output
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_BOOT;
      r_cnt        <= '0;
      r_pend       <= DIV_W'(DIV_RESET);
      r_div_val    <= DIV_W'(DIV_RESET);
      r_div_resetn <= 1'b0;
      r_gate_en    <= 1'b0;
      r_req_ready  <= 1'b0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_cnt  <= w_cnt_inc;
      case (r_state)
        ST_BOOT: begin
          r_state      <= ST_RESET;
          r_cnt        <= '0;
          r_div_val    <= r_pend;
          r_div_resetn <= 1'b0;
        end
        ST_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            if (bus.req_div < DIV_W'(DIV_MIN)) begin
              r_err <= 1'b1;
            end else if (bus.req_div == r_div_val) begin
              r_done <= 1'b1;
            end else begin
              r_pend      <= bus.req_div;
              r_state     <= ST_WAIT_LOW;
              r_cnt       <= '0;
              r_req_ready <= 1'b0;
              r_busy      <= 1'b1;
            end
          end
        end
        ST_WAIT_LOW: begin
          if ((w_low2 && (r_cnt != '0)) || w_wl_tmo) begin
            r_state   <= ST_GATE;
            r_cnt     <= '0;
            r_gate_en <= 1'b0;
          end
        end
        ST_GATE: begin
          if (r_cnt == CNT_W'(GATE_CYC - 1)) begin
            r_state      <= ST_RESET;
            r_cnt        <= '0;
            r_div_val    <= r_pend;
            r_div_resetn <= 1'b0;
          end
        end
        ST_RESET: begin
          if (r_cnt == CNT_W'(RST_CYC - 1)) begin
            r_state      <= ST_RELEASE;
            r_cnt        <= '0;
            r_div_resetn <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (w_rise) begin
            r_state     <= ST_IDLE;
            r_gate_en   <= 1'b1;
            r_done      <= 1'b1;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else if (w_rel_tmo) begin
            r_state     <= ST_IDLE;
            r_err       <= 1'b1;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign div_val       = r_div_val;
  assign div_resetn    = r_div_resetn;
  assign gate_en       = r_gate_en;
  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Directed bench for clkdiv_cfg_ctrl with a behavioural odd_div model.
// Define CLKDIV_CFG_CTRL_TIMEOUT_EN to also exercise the release timeout.
module tb_clkdiv_cfg_ctrl;

  localparam int CLK_PERIOD = 10;

  logic       clk;
  logic       resetn;
  logic       clkout_in;
  logic [7:0] div_val;
  logic       div_resetn;
  logic       gate_en;

  logic       stuckLow;
  logic       modClk;
  int         modPh;
  longint     lastRise;
  longint     prevRise;

  int total;
  int bad;

  clkdiv_cfg_ctrl_if u_if ();

  clkdiv_cfg_ctrl #(
    .TMO_CYC (16)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (u_if),
    .clkout_in  (clkout_in),
    .div_val    (div_val),
    .div_resetn (div_resetn),
    .gate_en    (gate_en)
  );

  // System clock
  initial begin
    clk = 1'b0;
    forever #(CLK_PERIOD / 2) clk = ~clk;
  end

  // Behavioural divider: high for N/2 cycles, low for the rest; restarts high after reset
  always @(posedge clk) begin
    int n;
    int nx;
    n = int'(div_val);
    if (n < 1) n = 1;
    if (div_resetn !== 1'b1) begin
      modPh  <= n - 1;
      modClk <= 1'b0;
    end else begin
      nx = (modPh >= n - 1) ? 0 : modPh + 1;
      modPh  <= nx;
      modClk <= (nx < n / 2);
    end
  end

  assign clkout_in = modClk & ~stuckLow;

  // Timestamp divided-clock rising edges for period measurement
  always @(posedge modClk) begin
    prevRise = lastRise;
    lastRise = $time;
  end

  task automatic test_reset();
    logic [4:0] expDr   = 5'b11100;
    logic [4:0] expDone = 5'b10000;
    logic [4:0] expBusy = 5'b01111;
    logic [4:0] expGate = 5'b10000;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (div_val !== 8'd4) begin bad++; $display("[TB] FAIL rst_div_val got=%0d want=4", div_val); end
    total++; if (div_resetn !== 1'b0) begin bad++; $display("[TB] FAIL rst_div_resetn got=%b want=0", div_resetn); end
    total++; if (gate_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_gate_en got=%b want=0", gate_en); end
    total++; if (u_if.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%b want=0", u_if.req_ready); end
    total++; if (u_if.busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_busy got=%b want=1", u_if.busy); end
    total++; if ({u_if.done, u_if.err} !== 2'b00) begin bad++; $display("[TB] FAIL rst_pulses got=%b want=00", {u_if.done, u_if.err}); end
    resetn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++; if (div_resetn !== expDr[k-1]) begin bad++; $display("[TB] FAIL boot_div_resetn k=%0d got=%b want=%b", k, div_resetn, expDr[k-1]); end
      total++; if (u_if.done !== expDone[k-1]) begin bad++; $display("[TB] FAIL boot_done k=%0d got=%b want=%b", k, u_if.done, expDone[k-1]); end
      total++; if (u_if.busy !== expBusy[k-1]) begin bad++; $display("[TB] FAIL boot_busy k=%0d got=%b want=%b", k, u_if.busy, expBusy[k-1]); end
      total++; if (gate_en !== expGate[k-1]) begin bad++; $display("[TB] FAIL boot_gate k=%0d got=%b want=%b", k, gate_en, expGate[k-1]); end
    end
    @(negedge clk);
    total++; if (u_if.done !== 1'b0) begin bad++; $display("[TB] FAIL boot_done_pulse got=%b want=0", u_if.done); end
    total++; if (u_if.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL boot_ready got=%b want=1", u_if.req_ready); end
  endtask

  task automatic test_odd_reprogram();
    logic gPrev;
    logic h1;
    logic h2;
    int   lowCyc;
    bit   seenDone;
    bit   fell;
    @(negedge clk);
    u_if.req_div   = 8'd5;
    u_if.req_valid = 1'b1;
    total++; if (u_if.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL odd_ready got=%b want=1", u_if.req_ready); end
    h1 = clkout_in;
    h2 = 1'b1;
    @(posedge clk);
    #1 u_if.req_valid = 1'b0;
    gPrev = 1'b1; lowCyc = 0; seenDone = 0; fell = 0;
    for (int c = 0; c < 60 && !seenDone; c++) begin
      @(negedge clk);
      if (gPrev && !gate_en) begin
        fell = 1;
        total++; if ({h2, h1} !== 2'b00) begin bad++; $display("[TB] FAIL odd_gate_fall_high samples=%b want=00", {h2, h1}); end
      end
      if (div_resetn === 1'b0) begin
        lowCyc++;
        total++; if (div_val !== 8'd5) begin bad++; $display("[TB] FAIL odd_div_val_in_reset got=%0d want=5", div_val); end
      end
      if (u_if.done === 1'b1) begin
        seenDone = 1;
        total++; if (gate_en !== 1'b1) begin bad++; $display("[TB] FAIL odd_gate_at_done got=%b want=1", gate_en); end
      end
      gPrev = gate_en;
      h2 = h1;
      h1 = clkout_in;
    end
    total++; if (!seenDone) begin bad++; $display("[TB] FAIL odd_done_timeout got=none want=done"); end
    total++; if (!fell) begin bad++; $display("[TB] FAIL odd_gate_never_fell got=0 want=1"); end
    total++; if (lowCyc !== 2) begin bad++; $display("[TB] FAIL odd_reset_cycles got=%0d want=2", lowCyc); end
    repeat (20) @(negedge clk);
    total++; if (lastRise - prevRise !== longint'(5 * CLK_PERIOD)) begin bad++; $display("[TB] FAIL odd_period got=%0d want=%0d", lastRise - prevRise, 5 * CLK_PERIOD); end
  endtask

  task automatic test_sweep();
    logic [7:0] vals [4];
    int dones;
    bit acc;
    bit fin;
    vals[0] = 8'd3; vals[1] = 8'd7; vals[2] = 8'd6; vals[3] = 8'd8;
    dones = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      u_if.req_div   = vals[i];
      u_if.req_valid = 1'b1;
      acc = 0;
      for (int c = 0; c < 100 && !acc; c++) begin
        if (c != 0 || i != 0) @(negedge clk);
        if (u_if.done === 1'b1) dones++;
        if (u_if.req_ready === 1'b1) begin
          total++; if (u_if.busy !== 1'b0) begin bad++; $display("[TB] FAIL sweep_accept_busy i=%0d got=%b want=0", i, u_if.busy); end
          @(posedge clk);
          #1 acc = 1;
        end
      end
      total++; if (!acc) begin bad++; $display("[TB] FAIL sweep_accept i=%0d got=none want=accepted", i); end
    end
    u_if.req_valid = 1'b0;
    fin = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (u_if.done === 1'b1) begin dones++; fin = 1; end
    end
    total++; if (!fin) begin bad++; $display("[TB] FAIL sweep_last_done got=none want=done"); end
    total++; if (dones !== 4) begin bad++; $display("[TB] FAIL sweep_done_count got=%0d want=4", dones); end
    total++; if (div_val !== 8'd8) begin bad++; $display("[TB] FAIL sweep_final_div got=%0d want=8", div_val); end
  endtask

  task automatic test_reject();
    @(negedge clk);
    u_if.req_div   = 8'd1;
    u_if.req_valid = 1'b1;
    @(posedge clk);
    #1 u_if.req_valid = 1'b0;
    @(negedge clk);
    total++; if (u_if.err !== 1'b1) begin bad++; $display("[TB] FAIL rej_err got=%b want=1", u_if.err); end
    total++; if (u_if.done !== 1'b0) begin bad++; $display("[TB] FAIL rej_done got=%b want=0", u_if.done); end
    total++; if (div_val !== 8'd8) begin bad++; $display("[TB] FAIL rej_div_val got=%0d want=8", div_val); end
    total++; if ({u_if.req_ready, u_if.busy} !== 2'b10) begin bad++; $display("[TB] FAIL rej_ready_busy got=%b want=10", {u_if.req_ready, u_if.busy}); end
    @(negedge clk);
    total++; if (u_if.err !== 1'b0) begin bad++; $display("[TB] FAIL rej_err_pulse got=%b want=0", u_if.err); end
    u_if.req_div   = 8'd8;
    u_if.req_valid = 1'b1;
    @(posedge clk);
    #1 u_if.req_valid = 1'b0;
    @(negedge clk);
    total++; if ({u_if.done, u_if.err} !== 2'b10) begin bad++; $display("[TB] FAIL noop_done_err got=%b want=10", {u_if.done, u_if.err}); end
    total++; if (gate_en !== 1'b1) begin bad++; $display("[TB] FAIL noop_gate got=%b want=1", gate_en); end
    total++; if (u_if.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL noop_ready got=%b want=1", u_if.req_ready); end
  endtask

  task automatic test_latency();
    logic [5:0] expGate = 6'b000011;
    logic [5:0] expDr   = 6'b100111;
    logic [5:0] expNew  = 6'b111000;
    logic [7:0] expDiv;
    @(negedge clk);
    stuckLow = 1'b1;
    repeat (3) @(negedge clk);
    u_if.req_div   = 8'd4;
    u_if.req_valid = 1'b1;
    @(posedge clk);
    #1 u_if.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      expDiv = expNew[k-1] ? 8'd4 : 8'd8;
      total++; if (gate_en !== expGate[k-1]) begin bad++; $display("[TB] FAIL lat_gate k=%0d got=%b want=%b", k, gate_en, expGate[k-1]); end
      total++; if (div_resetn !== expDr[k-1]) begin bad++; $display("[TB] FAIL lat_div_resetn k=%0d got=%b want=%b", k, div_resetn, expDr[k-1]); end
      total++; if (div_val !== expDiv) begin bad++; $display("[TB] FAIL lat_div_val k=%0d got=%0d want=%0d", k, div_val, expDiv); end
      total++; if ({u_if.busy, u_if.req_ready} !== 2'b10) begin bad++; $display("[TB] FAIL lat_busy_ready k=%0d got=%b want=10", k, {u_if.busy, u_if.req_ready}); end
    end
    stuckLow = 1'b0;
    @(negedge clk);
    total++; if (u_if.done !== 1'b0) begin bad++; $display("[TB] FAIL lat_done_early got=%b want=0", u_if.done); end
    @(negedge clk);
    total++; if ({u_if.done, gate_en} !== 2'b11) begin bad++; $display("[TB] FAIL lat_done_gate got=%b want=11", {u_if.done, gate_en}); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    bit fin;
    @(negedge clk);
    u_if.req_div   = 8'd7;
    u_if.req_valid = 1'b1;
    @(posedge clk);
    #1 u_if.req_valid = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (div_resetn === 1'b0) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("[TB] FAIL mid_reach_reset got=none want=div_resetn0"); end
    total++; if (div_val !== 8'd7) begin bad++; $display("[TB] FAIL mid_div_val got=%0d want=7", div_val); end
    resetn = 1'b0;
    @(negedge clk);
    total++; if (div_val !== 8'd4) begin bad++; $display("[TB] FAIL mid_restore_div got=%0d want=4", div_val); end
    total++; if ({gate_en, div_resetn} !== 2'b00) begin bad++; $display("[TB] FAIL mid_gate_dr got=%b want=00", {gate_en, div_resetn}); end
    total++; if ({u_if.busy, u_if.req_ready} !== 2'b10) begin bad++; $display("[TB] FAIL mid_busy_ready got=%b want=10", {u_if.busy, u_if.req_ready}); end
    resetn = 1'b1;
    fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      if (u_if.done === 1'b1) fin = 1;
    end
    total++; if (!fin) begin bad++; $display("[TB] FAIL mid_reboot_done got=none want=done"); end
    total++; if (div_val !== 8'd4) begin bad++; $display("[TB] FAIL mid_reboot_div got=%0d want=4", div_val); end
  endtask

`ifdef CLKDIV_CFG_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    bit sawDone;
    @(negedge clk);
    stuckLow = 1'b1;
    repeat (3) @(negedge clk);
    u_if.req_div   = 8'd6;
    u_if.req_valid = 1'b1;
    @(posedge clk);
    #1 u_if.req_valid = 1'b0;
    sawDone = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (u_if.done === 1'b1) sawDone = 1;
      if (k == 21) begin
        total++; if (u_if.err !== 1'b0) begin bad++; $display("[TB] FAIL tmo_err_early got=%b want=0", u_if.err); end
      end
    end
    total++; if (u_if.err !== 1'b1) begin bad++; $display("[TB] FAIL tmo_err got=%b want=1", u_if.err); end
    total++; if (gate_en !== 1'b0) begin bad++; $display("[TB] FAIL tmo_gate got=%b want=0", gate_en); end
    total++; if ({u_if.req_ready, u_if.busy} !== 2'b10) begin bad++; $display("[TB] FAIL tmo_ready_busy got=%b want=10", {u_if.req_ready, u_if.busy}); end
    total++; if (div_val !== 8'd6) begin bad++; $display("[TB] FAIL tmo_div_val got=%0d want=6", div_val); end
    total++; if (sawDone) begin bad++; $display("[TB] FAIL tmo_unexpected_done got=1 want=0"); end
    stuckLow = 1'b0;
  endtask
`endif

  // Run every scenario in order, then report
  initial begin
    total          = 0;
    bad            = 0;
    resetn         = 1'b0;
    stuckLow       = 1'b0;
    lastRise       = 0;
    prevRise       = 0;
    u_if.req_valid = 1'b0;
    u_if.req_div   = 8'd0;
    test_reset();
    test_odd_reprogram();
    test_sweep();
    test_reject();
    test_latency();
    test_reset_mid();
`ifdef CLKDIV_CFG_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
